// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Package : sdram_pkg
// Brief   : Shared widths, typedefs and arbiter state encoding for the
//           SDRAM burst port.
// Rev     : 1.0  initial release
// ============================================================================
package sdram_pkg;

    localparam int C_BA_WIDTH    = 2;
    localparam int C_ROW_WIDTH   = 13;
    localparam int C_COL_WIDTH   = 9;
    localparam int C_DQ_WIDTH    = 16;
    localparam int C_BURST_WIDTH = 9;
    localparam int C_ADDR_WIDTH  = C_BA_WIDTH + C_ROW_WIDTH + C_COL_WIDTH;

    typedef logic [C_ADDR_WIDTH-1:0]  sdram_addr_t;
    typedef logic [C_BURST_WIDTH-1:0] burst_len_t;
    typedef logic [C_DQ_WIDTH-1:0]    dq_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module : rr_picker
// Brief  : Combinational round-robin pick: first asserted request scanning
//          upward from ptr, wrapping modulo NUM_PORTS.
// Rev    : 1.0  initial release
// ============================================================================
module rr_picker
    import sdram_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] pick_onehot,
    output logic [IDX_W-1:0]     pick_idx,
    output logic                 pick_valid
);

    localparam logic [IDX_W:0] C_NUM = (IDX_W+1)'(NUM_PORTS);

    always_comb begin
        logic [IDX_W:0] w_cand;
        pick_onehot = '0;
        pick_idx    = '0;
        pick_valid  = 1'b0;
        w_cand      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            // ptr < NUM_PORTS, so one conditional subtract is a full modulo
            w_cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (w_cand >= C_NUM) begin
                w_cand = w_cand - C_NUM;
            end
            if (!pick_valid && req[w_cand[IDX_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = w_cand[IDX_W-1:0];
            end
        end
        if (pick_valid) begin
            pick_onehot[pick_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module : sdram_burst_arbiter
// Brief  : Round-robin arbiter sharing the SDRAM controller burst port among
//          NUM_PORTS masters; grant is held for the whole burst.
// Rev    : 1.0  initial release
// ============================================================================
module sdram_burst_arbiter
    import sdram_pkg::*;
#(
    parameter int NUM_PORTS   = 3,
    parameter int BA_WIDTH    = C_BA_WIDTH,
    parameter int ROW_WIDTH   = C_ROW_WIDTH,
    parameter int COL_WIDTH   = C_COL_WIDTH,
    parameter int DQ_WIDTH    = C_DQ_WIDTH,
    parameter int ADDR_WIDTH  = BA_WIDTH + ROW_WIDTH + COL_WIDTH,
    parameter int BURST_WIDTH = C_BURST_WIDTH
) (
    input  logic                             clk,
    input  logic                             res,
    input  logic [NUM_PORTS-1:0]             m_req,
    input  logic [NUM_PORTS-1:0]             m_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  m_addr,
    input  logic [NUM_PORTS*BURST_WIDTH-1:0] m_len,
    output logic [NUM_PORTS-1:0]             m_gnt,
    input  logic [NUM_PORTS*DQ_WIDTH-1:0]    m_wdata,
    input  logic [NUM_PORTS-1:0]             m_wvalid,
    output logic [NUM_PORTS-1:0]             m_wready,
    output logic [DQ_WIDTH-1:0]              m_rdata,
    output logic [NUM_PORTS-1:0]             m_rvalid,
    output logic [NUM_PORTS-1:0]             m_done,
    output logic                             c_req,
    output logic                             c_we,
    output logic [ADDR_WIDTH-1:0]            c_addr,
    output logic [BURST_WIDTH-1:0]           c_len,
    input  logic                             c_ack,
    output logic [DQ_WIDTH-1:0]              c_wdata,
    output logic                             c_wvalid,
    input  logic                             c_wready,
    input  logic [DQ_WIDTH-1:0]              c_rdata,
    input  logic                             c_rvalid
);

    localparam int              IDX_W      = $clog2(NUM_PORTS);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_PORTS - 1);

    arb_state_e               r_state;
    logic [IDX_W-1:0]         r_rr_ptr;
    logic [IDX_W-1:0]         r_gnt_idx;
    logic [BURST_WIDTH-1:0]   r_beat_cnt;
    logic [NUM_PORTS-1:0]     r_gnt;
    logic [NUM_PORTS-1:0]     r_done;
    logic                     r_c_req;
    logic                     r_c_we;
    logic [ADDR_WIDTH-1:0]    r_c_addr;
    logic [BURST_WIDTH-1:0]   r_c_len;

    logic [NUM_PORTS-1:0]     w_pick_onehot;
    logic [IDX_W-1:0]         w_pick_idx;
    logic                     w_pick_valid;
    logic                     w_beat;

    logic [ADDR_WIDTH-1:0]    w_addr  [NUM_PORTS];
    logic [BURST_WIDTH-1:0]   w_len   [NUM_PORTS];
    logic [DQ_WIDTH-1:0]      w_wdata [NUM_PORTS];

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_unpack
            assign w_addr[g]  = m_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_len[g]   = m_len[g*BURST_WIDTH +: BURST_WIDTH];
            assign w_wdata[g] = m_wdata[g*DQ_WIDTH +: DQ_WIDTH];
        end
    endgenerate

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_picker (
        .req         (m_req),
        .ptr         (r_rr_ptr),
        .pick_onehot (w_pick_onehot),
        .pick_idx    (w_pick_idx),
        .pick_valid  (w_pick_valid)
    );

    // Data steering is only live in DATA; everywhere else all beats are ignored.
    always_comb begin
        m_wready = '0;
        m_rvalid = '0;
        m_rdata  = '0;
        c_wdata  = '0;
        c_wvalid = 1'b0;
        w_beat   = 1'b0;
        if (r_state == DATA) begin
            if (r_c_we) begin
                c_wdata              = w_wdata[r_gnt_idx];
                c_wvalid             = m_wvalid[r_gnt_idx];
                m_wready[r_gnt_idx]  = c_wready;
                w_beat               = m_wvalid[r_gnt_idx] && c_wready;
            end else begin
                m_rdata              = c_rdata;
                m_rvalid[r_gnt_idx]  = c_rvalid;
                w_beat               = c_rvalid;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_gnt_idx  <= '0;
            r_beat_cnt <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_c_req    <= 1'b0;
            r_c_we     <= 1'b0;
            r_c_addr   <= '0;
            r_c_len    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= '0;
                    if (w_pick_valid) begin
                        r_gnt_idx <= w_pick_idx;
                        r_gnt     <= w_pick_onehot;
                        r_c_we    <= m_we[w_pick_idx];
                        r_c_addr  <= w_addr[w_pick_idx];
                        // A zero-length request still moves one beat
                        r_c_len   <= (w_len[w_pick_idx] == '0) ? BURST_WIDTH'(1)
                                                               : w_len[w_pick_idx];
                        r_c_req   <= 1'b1;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (c_ack) begin
                        r_c_req    <= 1'b0;
                        r_beat_cnt <= '0;
                        r_state    <= DATA;
                    end
                end
                DATA: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + BURST_WIDTH'(1);
                        if ((r_beat_cnt + BURST_WIDTH'(1)) == r_c_len) begin
                            r_done  <= r_gnt;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_done   <= '0;
                    r_gnt    <= '0;
                    r_rr_ptr <= (r_gnt_idx == C_LAST_IDX) ? '0 : r_gnt_idx + 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_gnt  = r_gnt;
    assign m_done = r_done;
    assign c_req  = r_c_req;
    assign c_we   = r_c_we;
    assign c_addr = r_c_addr;
    assign c_len  = r_c_len;

endmodule
`default_nettype wire

// File: tb/tb_sdram_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_sdram_burst_arbiter
// Brief  : Directed self-checking bench for sdram_burst_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sdram_burst_arbiter;

    localparam int NP = 3;
    localparam int AW = 24;
    localparam int BW = 9;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              res;
    logic [NP-1:0]     m_req, m_we, m_gnt, m_wvalid, m_wready, m_rvalid, m_done;
    logic [NP*AW-1:0]  m_addr;
    logic [NP*BW-1:0]  m_len;
    logic [NP*DW-1:0]  m_wdata;
    logic [DW-1:0]     m_rdata, c_wdata, c_rdata;
    logic              c_req, c_we, c_ack, c_wvalid, c_wready, c_rvalid;
    logic [AW-1:0]     c_addr;
    logic [BW-1:0]     c_len;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sdram_burst_arbiter #(.NUM_PORTS(NP)) dut (
        .clk(clk), .res(res),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_len(m_len),
        .m_gnt(m_gnt), .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_done(m_done),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_len(c_len), .c_ack(c_ack),
        .c_wdata(c_wdata), .c_wvalid(c_wvalid), .c_wready(c_wready),
        .c_rdata(c_rdata), .c_rvalid(c_rvalid)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge; checks follow 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [DW-1:0] wdat [4];
    logic          rdy  [5];
    logic [NP-1:0] order [6];

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        res = 1'b0; m_req = '0; m_we = '0; m_addr = '0; m_len = '0;
        m_wdata = '0; m_wvalid = '0; c_ack = 1'b0; c_wready = 1'b0;
        c_rdata = '0; c_rvalid = 1'b0;
        wdat[0] = 16'hA000; wdat[1] = 16'hA001; wdat[2] = 16'hA002; wdat[3] = 16'hA003;
        rdy[0] = 1'b1; rdy[1] = 1'b0; rdy[2] = 1'b1; rdy[3] = 1'b1; rdy[4] = 1'b1;
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100;
        order[3] = 3'b001; order[4] = 3'b010; order[5] = 3'b100;

        // ---------------- reset state ----------------
        tick(); tick();
        check_eq("rst_gnt",   m_gnt,  0);
        check_eq("rst_creq",  c_req,  0);
        check_eq("rst_done",  m_done, 0);
        check_eq("rst_caddr", c_addr, 0);
        check_eq("rst_clen",  c_len,  0);
        res = 1'b1;

        // ---------------- port 0 write, len 4 ----------------
        m_req = 3'b001; m_we = 3'b001; m_addr[0*AW +: AW] = 24'h000100; m_len[0*BW +: BW] = 9'd4;
        settle();
        check_eq("w_idle_gnt", m_gnt, 0);
        tick();
        m_req = '0;
        settle();
        check_eq("w_gnt",   m_gnt,  3'b001);
        check_eq("w_creq",  c_req,  1);
        check_eq("w_caddr", c_addr, 24'h000100);
        check_eq("w_clen",  c_len,  4);
        check_eq("w_cwe",   c_we,   1);
        tick();
        check_eq("w_creq_hold", c_req, 1);
        c_ack = 1'b1;
        tick();
        c_ack = 1'b0;
        check_eq("w_creq_drop", c_req, 0);
        m_wvalid = 3'b001;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            c_wready = rdy[i];
            m_wdata[0*DW +: DW] = wdat[k];
            c_rvalid = (i == 1);
            settle();
            check_eq("w_cwvalid", c_wvalid, 1);
            check_eq("w_cwdata",  c_wdata,  wdat[k]);
            check_eq("w_wready",  m_wready, {2'b00, rdy[i]});
            check_eq("w_rvalid",  m_rvalid, 0);
            check_eq("w_nodone",  m_done,   0);
            if (rdy[i]) k++;
        end
        tick();
        m_wvalid = '0; c_wready = 1'b0; c_rvalid = 1'b0;
        settle();
        check_eq("w_done",     m_done,   3'b001);
        check_eq("w_done_gnt", m_gnt,    3'b001);
        check_eq("w_done_cwv", c_wvalid, 0);
        tick();
        c_rvalid = 1'b1; c_rdata = 16'hBEEF;
        settle();
        check_eq("w_post_done",  m_done,   0);
        check_eq("w_post_gnt",   m_gnt,    0);
        check_eq("idle_rvalid",  m_rvalid, 0);
        check_eq("idle_rdata",   m_rdata,  0);
        tick();
        c_rvalid = 1'b0;
        check_eq("idle_gnt", m_gnt, 0);

        // ---------------- ports 0 and 2 read from reset ----------------
        res = 1'b0;
        settle();
        tick();
        res = 1'b1;
        m_req = 3'b101; m_we = 3'b000;
        m_addr[0*AW +: AW] = 24'h123456; m_len[0*BW +: BW] = 9'd2;
        m_addr[2*AW +: AW] = 24'hABCDEF; m_len[2*BW +: BW] = 9'd3;
        tick();
        m_req = 3'b100; c_ack = 1'b1;
        check_eq("r0_gnt",   m_gnt,  3'b001);
        check_eq("r0_caddr", c_addr, 24'h123456);
        check_eq("r0_clen",  c_len,  2);
        check_eq("r0_cwe",   c_we,   0);
        for (int b = 0; b < 2; b++) begin
            tick();
            c_ack = 1'b0; c_rvalid = 1'b1; c_rdata = 16'h1000 + 16'(b);
            settle();
            check_eq("r0_rvalid", m_rvalid, 3'b001);
            check_eq("r0_rdata",  m_rdata,  16'h1000 + 16'(b));
        end
        tick();
        c_rvalid = 1'b0;
        check_eq("r0_done", m_done, 3'b001);
        tick();
        check_eq("r_turn_gnt", m_gnt, 0);
        tick();
        m_req = '0; c_ack = 1'b1;
        check_eq("r2_gnt",   m_gnt,  3'b100);
        check_eq("r2_caddr", c_addr, 24'hABCDEF);
        check_eq("r2_clen",  c_len,  3);
        for (int b = 0; b < 3; b++) begin
            tick();
            c_ack = 1'b0; c_rvalid = 1'b1; c_rdata = 16'h2000 + 16'(b);
            settle();
            check_eq("r2_rvalid", m_rvalid, 3'b100);
            check_eq("r2_rdata",  m_rdata,  16'h2000 + 16'(b));
        end
        tick();
        c_rvalid = 1'b0;
        check_eq("r2_done", m_done, 3'b100);
        tick();

        // ---------------- all ports continuously, len 1 ----------------
        m_req = 3'b111; m_we = 3'b000; m_len = {9'd1, 9'd1, 9'd1};
        c_ack = 1'b1; c_rvalid = 1'b1; c_rdata = 16'h5A5A;
        for (int n = 0; n < 6; n++) begin
            tick();
            check_eq("rr_gnt", m_gnt, order[n]);
            tick();
            check_eq("rr_rvalid", m_rvalid, order[n]);
            tick();
            check_eq("rr_done", m_done, order[n]);
            tick();
        end
        m_req = '0; c_ack = 1'b0; c_rvalid = 1'b0;

        // ---------------- port 1 read with zero length ----------------
        m_req = 3'b010; m_addr[1*AW +: AW] = 24'h000777; m_len[1*BW +: BW] = 9'd0;
        tick();
        m_req = '0; c_ack = 1'b1;
        check_eq("z_gnt",  m_gnt, 3'b010);
        check_eq("z_clen", c_len, 1);
        tick();
        c_ack = 1'b0; c_rvalid = 1'b1;
        settle();
        check_eq("z_rvalid", m_rvalid, 3'b010);
        tick();
        c_rvalid = 1'b0;
        check_eq("z_done", m_done, 3'b010);
        tick();

        // ---------------- reset mid-burst ----------------
        m_req = 3'b001; m_len[0*BW +: BW] = 9'd8;
        tick();
        m_req = '0; c_ack = 1'b1;
        check_eq("x_gnt", m_gnt, 3'b001);
        tick();
        c_ack = 1'b0; c_rvalid = 1'b1;
        tick();
        tick();
        check_eq("x_rvalid", m_rvalid, 3'b001);
        res = 1'b0;
        settle();
        check_eq("x_rst_gnt",    m_gnt,    0);
        check_eq("x_rst_creq",   c_req,    0);
        check_eq("x_rst_done",   m_done,   0);
        check_eq("x_rst_rvalid", m_rvalid, 0);
        tick();
        res = 1'b1; c_rvalid = 1'b0; m_req = 3'b110;
        tick();
        m_req = '0;
        check_eq("x_ptr_gnt", m_gnt, 3'b010);
        check_eq("x_ptr_done", m_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_burst_arbiter.md
Name: sdram_burst_arbiter

Overview:
- Shares the single burst command/data port of the SDRAM controller between NUM_PORTS requesters, such as the frame reader, the frame writer and the CPU bridge.
- Uses round-robin arbitration and locks the grant for the whole burst.
- Latches the winning command, forwards it to the controller, steers data beats to and from the granted port, counts beats and signals completion.

Parameters:
- NUM_PORTS, 3, number of requesters (2..8).
- BA_WIDTH, 2, bank address bits.
- ROW_WIDTH, 13, row address bits.
- COL_WIDTH, 9, column address bits.
- DQ_WIDTH, 16, data beat width.
- ADDR_WIDTH, BA_WIDTH+ROW_WIDTH+COL_WIDTH (24), word address width.
- BURST_WIDTH, 9, burst length field width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- res  in  1  asynchronous active-low reset.
- m_req  in  NUM_PORTS  per-port burst request.
- m_we  in  NUM_PORTS  per-port direction (1 = write).
- m_addr  in  NUM_PORTS*ADDR_WIDTH  per-port start address.
- m_len  in  NUM_PORTS*BURST_WIDTH  per-port beat count.
- m_gnt  out  NUM_PORTS  one-hot grant, registered.
- m_wdata  in  NUM_PORTS*DQ_WIDTH  per-port write data.
- m_wvalid  in  NUM_PORTS  per-port write beat valid.
- m_wready  out  NUM_PORTS  per-port write beat ready.
- m_rdata  out  DQ_WIDTH  read data, broadcast to all ports.
- m_rvalid  out  NUM_PORTS  per-port read beat valid.
- m_done  out  NUM_PORTS  one-cycle burst-complete pulse, registered.
- c_req  out  1  command request to controller.
- c_we  out  1  command direction.
- c_addr  out  ADDR_WIDTH  command address.
- c_len  out  BURST_WIDTH  command beat count.
- c_ack  in  1  controller accepted command.
- c_wdata  out  DQ_WIDTH  write beat to controller.
- c_wvalid  out  1  write beat valid.
- c_wready  in  1  controller accepts write beat.
- c_rdata  in  DQ_WIDTH  read beat from controller.
- c_rvalid  in  1  read beat valid.

Behaviour:
- Reset (res low, async):
  - state=IDLE; rr_ptr=0; gnt_idx=0; beat_cnt=0.
  - m_gnt=0, m_done=0, c_req=0, c_we=0, c_addr=0, c_len=0.
  - All combinational steering outputs evaluate to 0 in IDLE.
- FSM states: IDLE, ISSUE, DATA, DONE.
- IDLE:
  - If any m_req, pick the first asserted port scanning rr_ptr, rr_ptr+1, ... mod NUM_PORTS.
  - Register gnt_idx; m_gnt one-hot.
  - Latch c_we, c_addr, c_len from that port.
  - A latched len of 0 is forced to 1.
  - Assert c_req; go to ISSUE. Arbitration takes one cycle.
- ISSUE:
  - Hold c_req and command fields stable until c_ack is sampled high.
  - Then drop c_req, clear beat_cnt, go to DATA.
- DATA:
  - Write: c_wdata/c_wvalid = m_wdata/m_wvalid[gnt_idx]; m_wready[gnt_idx] = c_wready. A beat is counted when c_wvalid && c_wready.
  - Read: m_rdata = c_rdata; m_rvalid[gnt_idx] = c_rvalid. A beat is counted on c_rvalid.
  - All non-granted ports see wready=0 and rvalid=0.
  - When a counted beat makes beat_cnt+1 == c_len, go to DONE.
  - beat_cnt is BURST_WIDTH bits and never wraps, since c_len ≤ 2^BURST_WIDTH-1.
- DONE (one cycle):
  - m_done[gnt_idx]=1; m_gnt cleared at the end of the cycle.
  - rr_ptr = gnt_idx+1 mod NUM_PORTS; return to IDLE.
  - Turnaround between bursts is therefore ≥2 idle cycles.
- Request rules:
  - Masters hold m_req until m_gnt. Request fields are sampled only on the IDLE→grant edge.
  - A requester may drop m_req before grant with no effect.
  - m_req held high after m_done is treated as a new request.
- Ignored inputs:
  - c_rvalid outside DATA, or during a write burst, is ignored. Extra beats from the controller are a protocol violation and are not counted.
  - c_ack outside ISSUE is ignored.
- Simultaneous requests: resolved strictly by rr_ptr order. No port waits more than NUM_PORTS-1 bursts.
- Reset mid-burst: immediate return to IDLE; grant and counter cleared; the burst in flight is abandoned and no m_done is issued.

Decomposition:
- Shared package sdram_pkg:
  - sdram_addr_t, burst_len_t, dq_t typedefs.
  - arb_state_e enum {IDLE, ISSUE, DATA, DONE}.
  - Width constants BA/ROW/COL/DQ/BURST.
- Sub-module rr_picker: combinational round-robin pick of a NUM_PORTS request vector from rr_ptr, giving a one-hot result plus index and valid.

Test Plan:
- Port 0 write, addr 0x000100, len 4, c_ack after 2 cycles, c_wready toggling 1,0,1,1,1 → 4 beats forwarded in order, m_done[0] pulses one cycle after the 4th beat.
- Ports 0 and 2 request reads simultaneously from reset → port 0 granted first, then port 2. m_rvalid reaches only the granted port; c_len matches each port's len.
- All 3 ports continuously requesting len 1 → grant order 0,1,2,0,1,2; no port waits more than 2 bursts.
- Port 1 read with m_len=0 → c_len=1; a single c_rvalid beat completes the burst.
- Reset asserted during DATA at beat 2 of 8 → m_gnt, c_req and m_done go 0 immediately; after release, state is IDLE and rr_ptr is 0.
- c_rvalid pulsed while in IDLE, and during a write burst → no m_rvalid output and beat_cnt unchanged.
